// File: rtl/clksrc_pkg.sv
// Shared types and default timing for the clock-source select sequencer.
package clksrc_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH, SETTLE} state_t;

  // bit0 = external fast source, bit1 = 100 Hz slow clock (vs push-button)
  localparam logic [1:0] SEL_FPGA_100HZ = 2'b10;
  localparam logic [1:0] SEL_EXT_100HZ  = 2'b11;
  localparam logic [1:0] SEL_FPGA_BTN   = 2'b00;
  localparam logic [1:0] SEL_EXT_BTN    = 2'b01;

  localparam int DEF_WINDOW    = 50000;
  localparam int DEF_MIN_EDGES = 6400;
  localparam int DEF_MAX_EDGES = 6700;
  localparam int DEF_QUAL      = 2;
  localparam int DEF_HOLD      = 16;
  localparam int DEF_SETTLE    = 1024;

endpackage

// File: rtl/clksrc_ctrl_clkmon.sv
// External clock monitor: synchronise, count rising edges per window and
// declare the source good after QUAL consecutive in-range windows.
module clkmon
  import clksrc_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int MAX_EDGES = DEF_MAX_EDGES,
  parameter int QUAL      = DEF_QUAL
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_src_ext,
  output logic ext_ok
);

  localparam int EDGE_W = $clog2(MAX_EDGES + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int GOOD_W = $clog2(QUAL + 1);

  logic              sync_p0, sync_p1, sync_p2;
  logic              rise, win_end, win_good;
  logic [EDGE_W-1:0] edge_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [GOOD_W-1:0] good_cnt;

  assign rise     = sync_p1 & ~sync_p2;
  assign win_end  = (win_cnt == WIN_W'(WINDOW - 1));
  assign win_good = (edge_cnt >= EDGE_W'(MIN_EDGES)) && (edge_cnt <= EDGE_W'(MAX_EDGES));
  assign ext_ok   = (good_cnt == GOOD_W'(QUAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      edge_cnt <= '0;
      win_cnt  <= '0;
      good_cnt <= '0;
    end else begin
      // p0/p1: metastability stages; p2: previous value for edge detect
      sync_p0 <= clk_src_ext;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      if (win_end) begin
        win_cnt  <= '0;
        // an edge seen on the terminal cycle belongs to the next window
        edge_cnt <= EDGE_W'(rise);
        if (!win_good)
          good_cnt <= '0;
        else if (!ext_ok)
          good_cnt <= good_cnt + 1'b1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (rise && (edge_cnt != '1))
          edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clksrc_ctrl.sv
// Clock-source select sequencer: stop, switch, settle, release, with forced
// fallback to the board-derived clock when the selected external clock is lost.
module clksrc_ctrl
  import clksrc_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int MAX_EDGES = DEF_MAX_EDGES,
  parameter int QUAL      = DEF_QUAL,
  parameter int HOLD      = DEF_HOLD,
  parameter int SETTLE    = DEF_SETTLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_src_ext,
  input  logic       req_ext,
  input  logic       req_button,
  output logic [1:0] clk_src_sel,
  output logic       clk_en,
  output logic       ext_ok,
  output logic       busy,
  output logic       fault
);

  localparam int CNT_MAX = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       lat, lat_nxt, sel_nxt, target;
  logic             fault_nxt, ext_ok_q, ext_lost;

  clkmon #(
    .WINDOW    (WINDOW),
    .MIN_EDGES (MIN_EDGES),
    .MAX_EDGES (MAX_EDGES),
    .QUAL      (QUAL)
  ) u_clkmon (
    .clk         (clk),
    .rst         (rst),
    .clk_src_ext (clk_src_ext),
    .ext_ok      (ext_ok)
  );

  assign target   = {~req_button, req_ext & ext_ok};
  assign ext_lost = clk_src_sel[0] & ext_ok_q & ~ext_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= clksrc_pkg::SETTLE;
      cnt         <= '0;
      lat         <= SEL_FPGA_100HZ;
      clk_src_sel <= SEL_FPGA_100HZ;
      fault       <= 1'b0;
      ext_ok_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lat         <= lat_nxt;
      clk_src_sel <= sel_nxt;
      fault       <= fault_nxt;
      ext_ok_q    <= ext_ok;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_nxt   = lat;
    sel_nxt   = clk_src_sel;
    fault_nxt = fault;
    clk_en    = 1'b0;
    busy      = 1'b1;
    case (state)
      RUN: begin
        clk_en = 1'b1;
        busy   = 1'b0;
        if (!req_ext)
          fault_nxt = 1'b0;
        if (target != clk_src_sel) begin
          state_nxt = DRAIN;
          lat_nxt   = target;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = SWITCH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SWITCH: begin
        sel_nxt   = lat;
        state_nxt = clksrc_pkg::SETTLE;
        cnt_nxt   = '0;
      end
      clksrc_pkg::SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // losing the selected external clock overrides whatever is in flight
    if (ext_lost) begin
      state_nxt = DRAIN;
      cnt_nxt   = '0;
      sel_nxt   = clk_src_sel;
      fault_nxt = 1'b1;
      lat_nxt   = {(state == RUN) ? target[1] : lat[1], 1'b0};
    end
  end

endmodule
